// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and defaults for the nibble serial adder.
// State encoding and default width/length constants.
package nsa_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam int W_DEF         = 4;
    localparam int MAX_BEATS_DEF = 16;

endpackage

// File: rtl/nibble_serial_adder_add_slice.sv
// Combinational W-bit ripple adder; also exposes the carry into the MSB.
// Zero latency, no flow control.
module add_slice
    import nsa_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);

    logic [W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = ci;
        for (int i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign co    = c[W];
    assign c_msb = c[W-1];

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-word serial adder, LSB word first, carry registered between beats (OVFL_DETECT_EN adds out_ovf).
// Latency: 1 cycle accept-to-out_valid, 1 beat/cycle.
// Backpressure: in_ready = !out_valid || out_ready; outputs hold while stalled.
module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter  int W         = W_DEF,
    parameter  int MAX_BEATS = MAX_BEATS_DEF,
    localparam int CNT_W     = $clog2(MAX_BEATS) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_a,
    input  logic [W-1:0]     in_b,
    input  logic             in_cin,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum,
    output logic             out_last,
    output logic             out_cout,
    output logic [CNT_W-1:0] out_cnt,
`ifdef OVFL_DETECT_EN
    output logic             out_ovf,
`endif
    output logic             len_err
);

    state_t             state_q, state_d;
    logic               carry_q, carry_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       out_sum_q, out_sum_d;
    logic               out_last_q, out_last_d;
    logic               out_cout_q, out_cout_d;
    logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
    logic               len_err_q, len_err_d;

    logic               accept;
    logic               is_first;
    logic               carry_used;
    logic [W-1:0]       slice_s;
    logic               slice_co;
    logic               slice_c_msb;

    assign in_ready   = !out_valid_q || out_ready;
    assign accept     = in_valid && in_ready;
    // Any beat taken in IDLE opens a packet, whatever in_first says.
    assign is_first   = (state_q == IDLE) || in_first;
    assign carry_used = is_first ? in_cin : carry_q;

    add_slice #(.W(W)) u_slice (
        .a     (in_a),
        .b     (in_b),
        .ci    (carry_used),
        .s     (slice_s),
        .co    (slice_co),
        .c_msb (slice_c_msb)
    );

    always_comb begin
        state_d     = state_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q && !out_ready;
        out_sum_d   = out_sum_q;
        out_last_d  = out_last_q;
        out_cout_d  = out_cout_q;
        out_cnt_d   = out_cnt_q;
        len_err_d   = len_err_q;
        if (accept) begin
            state_d     = in_last ? IDLE : BUSY;
            carry_d     = slice_co;
            out_valid_d = 1'b1;
            out_sum_d   = slice_s;
            out_last_d  = in_last;
            out_cout_d  = slice_co;
            if (is_first) begin
                out_cnt_d = CNT_W'(1);
            end else if (out_cnt_q == CNT_W'(MAX_BEATS)) begin
                // Counter pinned at MAX_BEATS: this beat is one too many.
                len_err_d = 1'b1;
            end else begin
                out_cnt_d = out_cnt_q + CNT_W'(1);
            end
        end
    end

`ifdef OVFL_DETECT_EN
    logic ovf_q, ovf_d;

    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = in_last && (slice_c_msb ^ slice_co);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign out_ovf = ovf_q;
`else
    logic unused_c_msb;
    assign unused_c_msb = slice_c_msb;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_last_q  <= 1'b0;
            out_cout_q  <= 1'b0;
            out_cnt_q   <= '0;
            len_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_last_q  <= out_last_d;
            out_cout_q  <= out_cout_d;
            out_cnt_q   <= out_cnt_d;
            len_err_q   <= len_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sum   = out_sum_q;
    assign out_last  = out_last_q;
    assign out_cout  = out_cout_q;
    assign out_cnt   = out_cnt_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Randomized and directed bench for nibble_serial_adder against a whole-packet integer-sum model.
// Build with OVFL_DETECT_EN defined to also cover out_ovf.
module tb_nibble_serial_adder;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_a = '0;
    logic [3:0] in_b = '0;
    logic       in_cin = 1'b0;
    logic       in_first = 1'b0;
    logic       in_last = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [3:0] out_sum;
    logic       out_last;
    logic       out_cout;
    logic [4:0] out_cnt;
    logic       len_err;
`ifdef OVFL_DETECT_EN
    logic       out_ovf;
`endif

    always #5 clk = ~clk;

    nibble_serial_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .out_cnt   (out_cnt),
`ifdef OVFL_DETECT_EN
        .out_ovf   (out_ovf),
`endif
        .len_err   (len_err)
    );

    typedef struct packed {
        logic       vld;
        logic [3:0] sum;
        logic       cout;
        logic       last;
        logic [4:0] cnt;
        logic       lerr;
        logic       ovf;
    } obs_t;

    int n_vec = 0;
    int n_err = 0;

    // Model: whole packet operands accumulated as wide integers.
    obs_t         exp_o;
    bit           m_open;
    bit           m_lenerr;
    logic [127:0] m_a, m_b;
    logic         m_cin;
    int           m_k;

    function automatic obs_t dut_obs();
        obs_t o;
        o.vld  = out_valid;
        o.sum  = out_sum;
        o.cout = out_cout;
        o.last = out_last;
        o.cnt  = out_cnt;
        o.lerr = len_err;
`ifdef OVFL_DETECT_EN
        o.ovf  = out_ovf;
`else
        o.ovf  = 1'b0;
`endif
        return o;
    endfunction

    task automatic model_reset();
        exp_o    = '0;
        m_open   = 0;
        m_lenerr = 0;
        m_k      = 0;
    endtask

    task automatic model_accept(input logic [3:0] a, input logic [3:0] b, input logic cin,
                                input logic first, input logic last);
        logic [127:0] tot;
        int k;
        if (!m_open || first) begin
            m_a = '0; m_b = '0; m_cin = cin; m_k = 0;
        end
        k   = m_k;
        m_a = m_a | ({124'd0, a} << (4 * k));
        m_b = m_b | ({124'd0, b} << (4 * k));
        tot = m_a + m_b + {127'd0, m_cin};
        m_k++;
        if (m_k > 16) m_lenerr = 1;
        exp_o.vld  = 1'b1;
        exp_o.sum  = tot[4*k +: 4];
        exp_o.cout = tot[4*k+4];
        exp_o.last = last;
        exp_o.cnt  = (m_k > 16) ? 5'd16 : 5'(m_k);
        exp_o.lerr = m_lenerr;
`ifdef OVFL_DETECT_EN
        exp_o.ovf  = last && (m_a[4*k+3] == m_b[4*k+3]) && (tot[4*k+3] != m_a[4*k+3]);
`else
        exp_o.ovf  = 1'b0;
`endif
        m_open = !last;
    endtask

    task automatic drive(input logic [3:0] a, input logic [3:0] b, input logic cin,
                         input logic first, input logic last);
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_first = first; in_last = last;
    endtask

    task automatic cycle(output bit acc);
        acc = in_valid && (!exp_o.vld || out_ready);
        @(posedge clk);
        if (acc) model_accept(in_a, in_b, in_cin, in_first, in_last);
        else if (out_ready) exp_o.vld = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (dut_obs() !== obs_t'(0) || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_state got=%h rdy=%b exp=%h rdy=1", dut_obs(), in_ready, obs_t'(0));
        end
        rst = 1'b0;
    endtask

    task automatic test_single_beat();
        bit acc;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            drive(4'b1010, 4'b1111, c[0], 1'b1, 1'b1);
            cycle(acc);
            n_vec++;
            if (dut_obs() !== exp_o || out_sum !== (c == 0 ? 4'b1001 : 4'b1010) || out_cout !== 1'b1
                || out_cnt !== 5'd1 || out_last !== 1'b1) begin
                n_err++;
                $display("FAIL single_beat cin=%0d got=%h exp=%h", c, dut_obs(), exp_o);
            end
        end
        in_valid = 1'b0;
        cycle(acc);
    endtask

    task automatic test_two_beat();
        bit acc;
        logic [3:0] sums [2];
        drive(4'hF, 4'h1, 1'b0, 1'b1, 1'b0);
        cycle(acc);
        sums[0] = out_sum;
        n_vec++;
        if (dut_obs() !== exp_o || out_sum !== 4'h0 || out_cout !== 1'b1) begin
            n_err++;
            $display("FAIL two_beat_b1 got=%h exp=%h", dut_obs(), exp_o);
        end
        drive(4'h2, 4'h3, 1'b0, 1'b0, 1'b1);
        cycle(acc);
        sums[1] = out_sum;
        n_vec++;
        if (dut_obs() !== exp_o || {sums[1], sums[0]} !== 8'h60 || out_cout !== 1'b0 || out_cnt !== 5'd2) begin
            n_err++;
            $display("FAIL two_beat_b2 got=%h result=%h exp=%h result=60", dut_obs(), {sums[1], sums[0]}, exp_o);
        end
        in_valid = 1'b0;
        cycle(acc);
    endtask

    task automatic test_backpressure();
        bit acc;
        obs_t held;
        out_ready = 1'b1;
        drive(4'h9, 4'h8, 1'b0, 1'b1, 1'b0);
        cycle(acc);
        held = exp_o;
        drive(4'h3, 4'h4, 1'b0, 1'b0, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (in_ready !== 1'b0 || dut_obs() !== held) begin
                n_err++;
                $display("FAIL backpressure_hold cyc=%0d rdy=%b got=%h exp rdy=0 %h", i, in_ready, dut_obs(), held);
            end
            cycle(acc);
        end
        out_ready = 1'b1;
        cycle(acc);
        n_vec++;
        if (!acc || dut_obs() !== exp_o || out_sum !== 4'h8 || out_cnt !== 5'd2) begin
            n_err++;
            $display("FAIL backpressure_release got=%h exp=%h", dut_obs(), exp_o);
        end
        in_valid = 1'b0;
        cycle(acc);
    endtask

    task automatic test_restart();
        bit acc;
        drive(4'hF, 4'hF, 1'b0, 1'b1, 1'b0);
        cycle(acc);
        drive(4'hF, 4'hF, 1'b1, 1'b0, 1'b0);
        cycle(acc);
        drive(4'h1, 4'h1, 1'b0, 1'b1, 1'b1);
        cycle(acc);
        n_vec++;
        if (dut_obs() !== exp_o || out_sum !== 4'h2 || out_cnt !== 5'd1 || len_err !== 1'b0) begin
            n_err++;
            $display("FAIL restart got=%h exp=%h", dut_obs(), exp_o);
        end
        in_valid = 1'b0;
        cycle(acc);
    endtask

    task automatic test_random_packets();
        bit acc;
        int len, tries;
        for (int p = 0; p < 40; p++) begin
            len = $urandom_range(1, 6);
            for (int b = 0; b < len; b++) begin
                drive(4'($urandom), 4'($urandom), 1'($urandom),
                      (b == 0) ? 1'($urandom) : ($urandom_range(0, 7) == 0),
                      b == len - 1);
                tries = 0;
                do begin
                    out_ready = ($urandom_range(0, 3) != 0);
                    #1;
                    n_vec++;
                    if (in_ready !== (!exp_o.vld || out_ready)) begin
                        n_err++;
                        $display("FAIL rand_in_ready got=%b exp=%b", in_ready, !exp_o.vld || out_ready);
                    end
                    cycle(acc);
                    n_vec++;
                    if (dut_obs() !== exp_o) begin
                        n_err++;
                        $display("FAIL rand_beat pkt=%0d beat=%0d got=%h exp=%h", p, b, dut_obs(), exp_o);
                    end
                    tries++;
                end while (!acc && tries < 50);
                if (!acc) begin
                    n_vec++; n_err++;
                    $display("FAIL rand_timeout pkt=%0d beat=%0d accepted=0 required=1", p, b);
                end
            end
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                cycle(acc);
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle(acc);
    endtask

    task automatic test_len_overflow();
        bit acc;
        out_ready = 1'b1;
        for (int b = 1; b <= 17; b++) begin
            drive(4'($urandom), 4'($urandom), 1'b0, b == 1, b == 17);
            cycle(acc);
            n_vec++;
            if (dut_obs() !== exp_o || (b >= 16 && out_cnt !== 5'd16)
                || len_err !== (b == 17)) begin
                n_err++;
                $display("FAIL len_overflow beat=%0d got=%h exp=%h", b, dut_obs(), exp_o);
            end
        end
        drive(4'h1, 4'h2, 1'b0, 1'b1, 1'b1);
        cycle(acc);
        n_vec++;
        if (dut_obs() !== exp_o || len_err !== 1'b1) begin
            n_err++;
            $display("FAIL len_err_sticky got=%h exp=%h", dut_obs(), exp_o);
        end
        in_valid = 1'b0;
        cycle(acc);
    endtask

    task automatic test_async_reset();
        bit acc;
        out_ready = 1'b0;
        drive(4'h5, 4'h6, 1'b1, 1'b1, 1'b0);
        cycle(acc);
        in_valid = 1'b0;
        n_vec++;
        if (out_valid !== 1'b1 || dut_obs() !== exp_o) begin
            n_err++;
            $display("FAIL pre_reset got=%h exp=%h", dut_obs(), exp_o);
        end
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_vec++;
        if (dut_obs() !== obs_t'(0)) begin
            n_err++;
            $display("FAIL async_reset got=%h exp=%h", dut_obs(), obs_t'(0));
        end
        #1 rst = 1'b0;
        out_ready = 1'b1;
        drive(4'b0111, 4'b0001, 1'b0, 1'b0, 1'b1);
        cycle(acc);
        n_vec++;
        if (dut_obs() !== exp_o || out_cnt !== 5'd1 || out_sum !== 4'h8) begin
            n_err++;
            $display("FAIL post_reset_first got=%h exp=%h", dut_obs(), exp_o);
        end
`ifdef OVFL_DETECT_EN
        n_vec++;
        if (out_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL ovf got=%b exp=1", out_ovf);
        end
`endif
        in_valid = 1'b0;
        cycle(acc);
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_two_beat();
        test_backpressure();
        test_restart();
        test_random_packets();
        test_len_overflow();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
